// File: rtl/dmem_bus_bridge_pkg.sv
// Shared types and constants for the data-memory bus bridge.
// States, funct3 access codes and the alignment helper.
package dmem_bus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    DONE
  } dmem_state_e;

  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_HALF  = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_BYTEU = 3'b100;
  localparam logic [2:0] F3_HALFU = 3'b101;

  function automatic logic is_misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    case (f3[1:0])
      2'b01:   m = off[0];
      2'b10:   m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_bus_bridge_if.sv
// System data-bus request/response channel.
// master = bridge side, slave = memory side.
interface dmem_bus_bridge_if #(
  parameter int XLEN = 32,
  parameter int ALEN = 32
);
  logic            bus_req_valid;
  logic            bus_req_ready;
  logic [ALEN-1:0] bus_addr;
  logic            bus_we;
  logic [3:0]      bus_be;
  logic [XLEN-1:0] bus_wdata;
  logic            bus_rsp_valid;
  logic [XLEN-1:0] bus_rsp_rdata;
  logic            bus_rsp_err;

  modport master (
    output bus_req_valid, bus_addr, bus_we,
    output bus_be, bus_wdata,
    input  bus_req_ready, bus_rsp_valid,
    input  bus_rsp_rdata, bus_rsp_err
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_we,
    input  bus_be, bus_wdata,
    output bus_req_ready, bus_rsp_valid,
    output bus_rsp_rdata, bus_rsp_err
  );
endinterface

// File: rtl/dmem_bus_bridge_load_extend.sv
// Load data lane extraction and sign/zero extension.
// Purely combinational; unknown funct3 returns the full word.
module dmem_bus_bridge_load_extend
  import dmem_bus_bridge_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      byte_off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{byte_off, 3'b000} +: 8];
  assign h = rdata[{byte_off[1], 4'b0000} +: 16];

  // select lane and extend by access type
  always_comb begin
    data = rdata;
    case (funct3)
      F3_BYTE:  data = {{(XLEN-8){b[7]}}, b};
      F3_HALF:  data = {{(XLEN-16){h[15]}}, h};
      F3_BYTEU: data = {{(XLEN-8){1'b0}}, b};
      F3_HALFU: data = {{(XLEN-16){1'b0}}, h};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// MEM-stage to system data bus bridge.
// Stalls the pipeline across a valid/ready request and response.
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ALEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ALEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_we,
  input  logic            dmem_re,
  input  logic [3:0]      dmem_be,
  input  logic [2:0]      dmem_funct3,
  output logic            mem_stall,
  output logic            mem_done,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned,
  output logic            access_fault,
  dmem_bus_bridge_if.master bus
);

  // WAIT_RSP spans TIMEOUT_CYCLES-1 cycles so that DONE
  // lands TIMEOUT_CYCLES cycles after the accepting cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 2);

  dmem_state_e state_q, state_d;

  logic [ALEN-1:0] addr_q;
  logic            we_q;
  logic [3:0]      be_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] wdata_q;
  logic [7:0]      cnt_q;
  logic [XLEN-1:0] load_q;
  logic            mis_q;
  logic            flt_q;
  logic [XLEN-1:0] ext_data;
  logic            acc;
  logic            mis_now;
  logic            timeout;

  assign acc     = dmem_we | dmem_re;
  assign mis_now = is_misaligned(dmem_funct3, dmem_addr[1:0]);
  assign timeout = (cnt_q == TO_LAST);

  dmem_bus_bridge_load_extend #(.XLEN(XLEN)) u_ext (
    .rdata    (bus.bus_rsp_rdata),
    .byte_off (addr_q[1:0]),
    .funct3   (f3_q),
    .data     (ext_data)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (acc) state_d = mis_now ? DONE : REQ;
      end
      REQ: begin
        if (bus.bus_req_ready) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (bus.bus_rsp_valid || timeout) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // capture the access when it leaves IDLE for the bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE && acc && !mis_now) begin
      addr_q  <= dmem_addr;
      we_q    <= dmem_we;
      be_q    <= dmem_be;
      f3_q    <= dmem_funct3;
      wdata_q <= dmem_wdata << {dmem_addr[1:0], 3'b000};
    end
  end

  // response timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == REQ && bus.bus_req_ready) begin
      cnt_q <= '0;
    end else if (state_q == WAIT_RSP) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // result and fault registers, held until the next access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q <= '0;
      mis_q  <= 1'b0;
      flt_q  <= 1'b0;
    end else if (state_q == IDLE && acc) begin
      load_q <= '0;
      mis_q  <= mis_now;
      flt_q  <= 1'b0;
    end else if (state_q == WAIT_RSP) begin
      if (bus.bus_rsp_valid) begin
        if (bus.bus_rsp_err) flt_q  <= 1'b1;
        else if (!we_q)      load_q <= ext_data;
      end else if (timeout) begin
        flt_q <= 1'b1;
      end
    end
  end

  assign bus.bus_req_valid = (state_q == REQ);
  assign bus.bus_addr      = {addr_q[ALEN-1:2], 2'b00};
  assign bus.bus_we        = we_q;
  assign bus.bus_be        = be_q;
  assign bus.bus_wdata     = wdata_q;

  assign mem_stall    = (state_q == IDLE && acc)
                     || (state_q == REQ)
                     || (state_q == WAIT_RSP);
  assign mem_done     = (state_q == DONE);
  assign load_data    = load_q;
  assign misaligned   = mis_q;
  assign access_fault = flt_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge.
// Driver issues accesses; a negedge monitor checks bus and results.
module tb_dmem_bus_bridge;

  localparam int TO = 255;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        flt;
    int          done_cyc;
    int          stalls;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        dmem_we = 1'b0;
  logic        dmem_re = 1'b0;
  logic [3:0]  dmem_be = '0;
  logic [2:0]  dmem_funct3 = '0;
  logic        mem_stall;
  logic        mem_done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        access_fault;

  dmem_bus_bridge_if #(.XLEN(32), .ALEN(32)) bus ();

  dmem_bus_bridge #(
    .XLEN(32), .ALEN(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_we      (dmem_we),
    .dmem_re      (dmem_re),
    .dmem_be      (dmem_be),
    .dmem_funct3  (dmem_funct3),
    .mem_stall    (mem_stall),
    .mem_done     (mem_done),
    .load_data    (load_data),
    .misaligned   (misaligned),
    .access_fault (access_fault),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stall_cnt = 0;
  exp_t exp_q[$];
  req_t req_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic bit ref_mis(input logic [2:0] f3,
                                 input logic [31:0] a);
    if (f3[1:0] == 2'b01) return (a % 2) != 0;
    if (f3[1:0] == 2'b10) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd,
                                           input int off,
                                           input logic [2:0] f3);
    logic [31:0] b, h;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 32'd256 : b;
      3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  // monitor: bus request fields and completion results
  always @(negedge clk) begin
    req_t r;
    exp_t e;
    if (!rst_n) begin
      stall_cnt = 0;
    end else begin
      if (bus.bus_req_valid) begin
        if (req_q.size() == 0) begin
          check("unexpected_req", 32'd1, 32'd0);
        end else begin
          r = req_q[0];
          check("bus_addr", bus.bus_addr, r.addr);
          check("bus_we", {31'd0, bus.bus_we}, {31'd0, r.we});
          check("bus_be", {28'd0, bus.bus_be}, {28'd0, r.be});
          check("bus_wdata", bus.bus_wdata, r.wdata);
          if (bus.bus_req_ready) void'(req_q.pop_front());
        end
      end
      if (mem_stall) stall_cnt++;
      if (mem_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("load_data", load_data, e.data);
          check("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
          check("access_fault", {31'd0, access_fault},
                {31'd0, e.flt});
          check("done_cycle", cyc, e.done_cyc);
          check("stall_cycles", stall_cnt, e.stalls);
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic do_access(
    input bit          we, re,
    input logic [31:0] addr, wd,
    input logic [3:0]  be,
    input logic [2:0]  f3,
    input int          rd, rspd,
    input bit          err, norsp,
    input logic [31:0] rdata
  );
    exp_t e;
    req_t r;
    int   issue;
    int   budget;
    bit   mis;
    mis   = ref_mis(f3, addr);
    issue = cyc;
    e.mis  = mis;
    e.flt  = 1'b0;
    e.data = '0;
    if (mis) begin
      e.done_cyc = issue + 1;
    end else begin
      r.addr  = addr & ~32'h3;
      r.we    = we;
      r.be    = be;
      r.wdata = wd << (8 * addr[1:0]);
      req_q.push_back(r);
      if (norsp) begin
        e.flt      = 1'b1;
        e.done_cyc = issue + 1 + rd + TO;
      end else begin
        e.done_cyc = issue + 3 + rd + rspd;
        if (err)      e.flt  = 1'b1;
        else if (!we) e.data = ref_load(rdata, int'(addr[1:0]), f3);
      end
    end
    e.stalls = e.done_cyc - issue;
    exp_q.push_back(e);
    dmem_addr   = addr;
    dmem_wdata  = wd;
    dmem_we     = we;
    dmem_re     = re;
    dmem_be     = be;
    dmem_funct3 = f3;
    if (!mis) begin
      @(posedge clk); #1;
      repeat (rd) begin @(posedge clk); #1; end
      bus.bus_req_ready = 1'b1;
      @(posedge clk); #1;
      bus.bus_req_ready = 1'b0;
      if (!norsp) begin
        repeat (rspd) begin @(posedge clk); #1; end
        bus.bus_rsp_valid = 1'b1;
        bus.bus_rsp_rdata = rdata;
        bus.bus_rsp_err   = err;
        @(posedge clk); #1;
        bus.bus_rsp_valid = 1'b0;
        bus.bus_rsp_err   = 1'b0;
        bus.bus_rsp_rdata = $urandom;
      end
    end
    budget = 0;
    while (!mem_done && budget < 400) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!mem_done) check("done_wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    dmem_we = 1'b0;
    dmem_re = 1'b0;
  endtask

  initial begin
    bus.bus_req_ready = 1'b0;
    bus.bus_rsp_valid = 1'b0;
    bus.bus_rsp_rdata = '0;
    bus.bus_rsp_err   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs",
          {28'd0, bus.bus_req_valid, mem_stall, mem_done,
           misaligned | access_fault}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_bus_addr", bus.bus_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    do_access(1, 0, 32'h100, 32'hDEADBEEF, 4'hF, 3'b010,
              0, 0, 0, 0, 32'h0);
    do_access(0, 1, 32'h203, 32'h0, 4'h8, 3'b000,
              0, 0, 0, 0, 32'h80FF1234);
    do_access(0, 1, 32'h203, 32'h0, 4'h8, 3'b100,
              1, 2, 0, 0, 32'h80FF1234);
    do_access(0, 1, 32'h202, 32'h0, 4'hC, 3'b101,
              0, 1, 0, 0, 32'h80FF1234);
    do_access(1, 0, 32'h11, 32'h0000ABCD, 4'h6, 3'b001,
              0, 0, 0, 0, 32'h0);
    do_access(1, 0, 32'h42, 32'h77, 4'h4, 3'b000,
              5, 0, 0, 0, 32'h0);
    do_access(0, 1, 32'h80, 32'h0, 4'hF, 3'b010,
              2, 0, 0, 1, 32'h0);
    do_access(0, 1, 32'h84, 32'h0, 4'hF, 3'b010,
              0, 1, 1, 0, 32'h5555AAAA);
    do_access(1, 1, 32'h88, 32'h12345678, 4'hF, 3'b010,
              0, 0, 0, 0, 32'hFFFFFFFF);

    // reset while waiting for a response
    do_access(0, 1, 32'h300, 32'h0, 4'hF, 3'b010,
              0, 0, 0, 0, 32'h12345678);
    begin
      req_t r;
      r.addr = 32'h304; r.we = 1'b0; r.be = 4'hF; r.wdata = '0;
      req_q.push_back(r);
    end
    dmem_addr = 32'h304; dmem_re = 1'b1;
    dmem_be = 4'hF; dmem_funct3 = 3'b010; dmem_wdata = '0;
    @(posedge clk); #1;
    bus.bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.bus_req_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    dmem_re = 1'b0;
    #1;
    check("midrst_outputs",
          {28'd0, bus.bus_req_valid, mem_stall, mem_done,
           misaligned | access_fault}, 32'd0);
    check("midrst_load_data", load_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.bus_rsp_valid = 1'b1;
    bus.bus_rsp_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.bus_rsp_valid = 1'b0;
    repeat (3) begin
      check("late_rsp_ignored",
            {29'd0, mem_done, mem_stall, bus.bus_req_valid}, 32'd0);
      @(posedge clk); #1;
    end
    do_access(0, 1, 32'h308, 32'h0, 4'hF, 3'b010,
              0, 0, 0, 0, 32'h0BADBEEF);

    // randomized accesses
    for (int i = 0; i < 60; i++) begin
      bit          st, rr, er, nr;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [3:0]  be;
      int          sz;
      int          sel;
      st = ($urandom_range(0, 1) == 1);
      rr = st ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (st) begin
        sel = $urandom_range(0, 2);
        f3  = 3'(sel);
      end else begin
        sel = $urandom_range(0, 5);
        case (sel)
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
          3: f3 = 3'b011; 4: f3 = 3'b100; default: f3 = 3'b101;
        endcase
      end
      sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      a  = $urandom & 32'h0000_0FFF;
      if (f3 == 3'b011 || $urandom_range(0, 3) != 0)
        a = a & ~(32'(sz) - 1);
      be = (sz == 1) ? 4'h1 : (sz == 2) ? 4'h3 : 4'hF;
      be = be << a[1:0];
      er = ($urandom_range(0, 9) == 0);
      nr = ($urandom_range(0, 24) == 0);
      do_access(st, rr, a, $urandom, be, f3,
                $urandom_range(0, 3), $urandom_range(0, 3),
                er, nr, $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (2) @(posedge clk);
    #1;
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("req_q_empty", req_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_bus_bridge.md
# dmem_bus_bridge

Sits between the MEM stage data-memory port and the system data bus. Converts the pipeline's single-cycle access (address, raw store data, byte enables, funct3) into a valid/ready request plus a response handshake, stalling the pipeline until completion. Lane-shifts store data and extracts, then sign- or zero-extends, load data for write-back. Flags misaligned accesses, bus errors and response timeouts instead of issuing or completing them.

## Interface
- XLEN, 32, data width
- ALEN, 32, address width
- TIMEOUT_CYCLES, 255, max cycles in WAIT_RSP before fault; 8-bit counter
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- dmem_addr  in  ALEN  byte address from MEM stage
- dmem_wdata  in  XLEN  unshifted store data (rs2 value, lane 0 aligned)
- dmem_we  in  1  store request
- dmem_re  in  1  load request (mem_read)
- dmem_be  in  4  byte enables from MEM stage
- dmem_funct3  in  3  access type/extension
- mem_stall  out  1  hold pipeline (MEM and earlier stages)
- mem_done  out  1  one-cycle completion pulse
- load_data  out  XLEN  extended load result, valid when mem_done
- misaligned  out  1  fault qualifier, valid with mem_done
- access_fault  out  1  bus error/timeout qualifier, valid with mem_done
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_addr  out  ALEN  word-aligned address ({addr[ALEN-1:2],2'b00})
- bus_we  out  1  write
- bus_be  out  4  byte enables
- bus_wdata  out  XLEN  lane-shifted store data
- bus_rsp_valid  in  1  response valid (one cycle)
- bus_rsp_rdata  in  XLEN  read word
- bus_rsp_err  in  1  error, qualified by bus_rsp_valid

## Operation
- States: IDLE, REQ, WAIT_RSP, DONE.
- IDLE: if (dmem_we|dmem_re): aligned → latch addr/we/be/funct3/shifted wdata, go REQ; misaligned → set misaligned, go DONE (no bus traffic). Else stay.
- Misaligned: HALF with addr[0]=1; WORD with addr[1:0]≠0. BYTE never misaligned.
- REQ: bus_req_valid=1, bus_* from latches, stable until bus_req_ready; on ready go WAIT_RSP, clear timeout counter.
- WAIT_RSP: on bus_rsp_valid: err → access_fault=1; else for loads register extended data. Go DONE. Counter reaches TIMEOUT_CYCLES without response → access_fault=1, go DONE.
- DONE: mem_done=1, go IDLE.
- mem_stall = (state==IDLE && (dmem_we|dmem_re)) || state==REQ || state==WAIT_RSP. Deasserted in DONE.
- bus_wdata = dmem_wdata << (8*addr[1:0]).
- Load extract: byte = rdata[8*addr[1:0] +: 8], half = rdata[16*addr[1] +: 16]. funct3 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero; other codes return full word.
- Stores return load_data = 0.
- dmem_we and dmem_re both set: store wins.
- bus_rsp_valid outside WAIT_RSP is ignored.

## Timing
- Reset (async assert, sync deassert by caller): state IDLE; all outputs 0, including bus_req_valid, mem_stall, mem_done, load_data, flags. bus_req_valid drops asynchronously mid-transaction, and the transaction is abandoned.
- Minimum aligned access: 4 cycles (IDLE, REQ with ready, WAIT_RSP with rsp, DONE); 3 stall cycles.
- Misaligned: 2 cycles (IDLE, DONE); 1 stall cycle.
- load_data, misaligned and access_fault are registered and held until the next access leaves IDLE.
- In DONE, inputs still reflect the finishing instruction. The pipeline advances at the end of DONE, and IDLE samples the next instruction the following cycle.

## Structure
- riscv_pkg: add `dmem_state_e` enum. Reuse F3_BYTE/F3_HALF/F3_WORD. Add F3_BYTEU/F3_HALFU if absent.
- Sub-module `load_extend`: combinational extract/extend (rdata, addr[1:0], funct3 → XLEN). The FSM, latches and timeout counter stay in the top.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, ready and rsp immediate → bus_addr 0x100, be 1111, wdata 0xDEADBEEF; stall 3 cycles; mem_done cycle 4, no flags.
- LB addr 0x203, rdata 0x80FF_1234 → load_data 0xFFFF_FF80. LBU same → 0x0000_0080. LHU addr 0x202 → 0x0000_80FF.
- SH addr 0x11, data 0x0000_ABCD → no bus request; misaligned=1 with mem_done cycle 2.
- SB addr 0x42, data 0x77; bus_req_ready held low 5 cycles → be 0100, wdata 0x0077_0000 stable throughout; stall held until DONE.
- LW with no response → access_fault=1, mem_done exactly TIMEOUT_CYCLES cycles after the ready cycle. Separately, rsp_err=1 → access_fault=1.
- rst_n low during WAIT_RSP, then a late rsp_valid → outputs 0, state IDLE, response ignored, next LW completes normally.
